tpu_writeback_master: RTL

- AXI4 write-burst engine that drains the Output Buffer (D results) to DDR after the control unit fires its writeback start pulse.
- Reads one 32-bit element per buffer address and issues INCR bursts of at most MAX_BURST beats, never crossing a 4 KB boundary.
- Pulses done_irq after the final write response; the control unit uses this pulse to leave its writeback-wait state.

---
 rtl/tpu_wb_pkg.sv | 35 +++
 rtl/wb_skid_fifo.sv | 42 ++++
 rtl/tpu_writeback_master.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/tpu_wb_pkg.sv
// Shared state encoding, AXI constants and burst sizing for the writeback master.
// Pure definitions: no latency, no flow control.
package tpu_wb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } wb_state_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned BOUNDARY_4K    = 4096;

    // Beats for the next burst: limited by what is left, the burst cap and the 4 KB page end.
    function automatic logic [8:0] calc_beats(
        input logic [15:0]  rem,
        input logic [31:0]  addr,
        input logic [8:0]   max_burst,
        input int unsigned  size_log2
    );
        logic [12:0] room_bytes;
        logic [16:0] room;
        logic [16:0] beats;
        room_bytes = 13'(BOUNDARY_4K) - {1'b0, addr[11:0]};
        room       = {4'b0, room_bytes >> size_log2};
        beats      = {1'b0, rem};
        if (beats > {8'b0, max_burst}) beats = {8'b0, max_burst};
        if (beats > room)              beats = room;
        return beats[8:0];
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO holding prefetched write beats (data plus last flag).
// Pop data is valid the cycle after push; the producer must never push when full.
module wb_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= push_dat;
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            count_q  <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign count   = count_q;

endmodule

// File: rtl/tpu_writeback_master.sv
// Drains the Output Buffer to DDR as AXI4 INCR bursts (<=MAX_BURST, no 4 KB crossing), one burst outstanding.
// Buffer read latency 1 cycle through a 2-entry skid FIFO; W stalls hold payload. Option WB_PERF_CNT_EN adds perf counters.
module tpu_writeback_master
    import tpu_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_pulse,
    input  logic [31:0]               dest_addr,
    input  logic [ADDR_WIDTH-1:0]     src_addr,
    input  logic [15:0]               length,
    output logic                      done_irq,
    output logic                      busy,
    output logic                      err,
`ifdef WB_PERF_CNT_EN
    output logic [31:0]               perf_busy_cycles,
    output logic [31:0]               perf_wstall_cycles,
`endif
    output logic [ADDR_WIDTH-1:0]     obuf_rd_addr,
    output logic                      obuf_rd_en,
    input  logic [DATA_WIDTH-1:0]     obuf_rd_data,
    output logic [31:0]               m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready
);

    localparam int unsigned SIZE_LOG2 = $clog2(DATA_WIDTH / 8);

    wb_state_e             state_q, state_d;
    logic [31:0]           cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [8:0]            rd_cnt_q, rd_cnt_d;
    logic                  err_q, err_d;
    logic                  inflight_q;
    logic                  inflight_last_q;

    logic [8:0]            beats;
    logic                  start_acc;
    logic                  rd_en;
    logic                  pop;
    logic                  fifo_full, fifo_empty;
    logic [1:0]            fifo_cnt;
    logic [1:0]            slots_free;
    logic [2:0]            slots_eff;
    logic [DATA_WIDTH:0]   head;

    assign beats     = {1'b0, awlen_q} + 9'd1;
    assign start_acc = (state_q == S_IDLE) && start_pulse;
    assign pop       = m_wvalid && m_wready;

    // A slot being popped this cycle is reusable by a read issued this cycle.
    assign slots_free = fifo_full ? 2'd0 : 2'd2 - fifo_cnt;
    assign slots_eff  = {1'b0, slots_free} + {2'b0, pop};
    assign rd_en      = ((state_q == S_AW) || (state_q == S_W))
                        && (rd_cnt_q < beats)
                        && (slots_eff > {2'b0, inflight_q});

    wb_skid_fifo #(.W(DATA_WIDTH + 1)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_dat ({inflight_last_q, obuf_rd_data}),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        awlen_d     = awlen_q;
        rd_cnt_d    = rd_cnt_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    cur_addr_d  = dest_addr;
                    rd_ptr_d    = src_addr;
                    remaining_d = length;
                    err_d       = 1'b0;
                    rd_cnt_d    = 9'd0;
                    if (length == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_AW;
                        awlen_d = 8'(calc_beats(length, dest_addr, 9'(MAX_BURST), SIZE_LOG2) - 9'd1);
                    end
                end
            end
            S_AW: if (m_awready) state_d = S_W;
            S_W: begin
                if (pop && head[DATA_WIDTH]) begin
                    state_d     = S_B;
                    remaining_d = remaining_q - {7'b0, beats};
                    cur_addr_d  = cur_addr_q + (32'(beats) << SIZE_LOG2);
                end
            end
            S_B: begin
                if (m_bvalid) begin
                    if (m_bresp != AXI_RESP_OKAY) err_d = 1'b1;
                    if (remaining_q != 16'd0) begin
                        state_d  = S_AW;
                        rd_cnt_d = 9'd0;
                        awlen_d  = 8'(calc_beats(remaining_q, cur_addr_q, 9'(MAX_BURST), SIZE_LOG2) - 9'd1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_cnt_d = rd_cnt_q + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cur_addr_q      <= '0;
            rd_ptr_q        <= '0;
            remaining_q     <= '0;
            awlen_q         <= '0;
            rd_cnt_q        <= '0;
            err_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            rd_ptr_q        <= rd_ptr_d;
            remaining_q     <= remaining_d;
            awlen_q         <= awlen_d;
            rd_cnt_q        <= rd_cnt_d;
            err_q           <= err_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && (rd_cnt_q == beats - 9'd1);
        end
    end

    assign busy         = (state_q == S_AW) || (state_q == S_W) || (state_q == S_B);
    assign done_irq     = (state_q == S_DONE);
    assign err          = err_q;
    assign obuf_rd_en   = rd_en;
    assign obuf_rd_addr = rd_ptr_q;
    assign m_awaddr     = cur_addr_q;
    assign m_awlen      = awlen_q;
    assign m_awsize     = 3'(SIZE_LOG2);
    assign m_awburst    = AXI_BURST_INCR;
    assign m_awvalid    = (state_q == S_AW);
    // W is gated by state so prefetched beats never run ahead of the AW handshake.
    assign m_wvalid     = (state_q == S_W) && !fifo_empty;
    assign m_wdata      = head[DATA_WIDTH-1:0];
    assign m_wlast      = m_wvalid && head[DATA_WIDTH];
    assign m_wstrb      = '1;
    assign m_bready     = (state_q == S_B);

`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_wstall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q   <= '0;
            perf_wstall_q <= '0;
        end else if (start_acc) begin
            perf_busy_q   <= '0;
            perf_wstall_q <= '0;
        end else begin
            if (busy)                   perf_busy_q   <= perf_busy_q + 32'd1;
            if (m_wvalid && !m_wready)  perf_wstall_q <= perf_wstall_q + 32'd1;
        end
    end

    assign perf_busy_cycles   = perf_busy_q;
    assign perf_wstall_cycles = perf_wstall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule
